// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetch front-end. Owns the fetch PC and keeps at most one read
//            outstanding to I-Memory over a request/acknowledge handshake.
//            Returned instructions are queued with their PCs in a DEPTH-entry
//            prefetch FIFO feeding decode. Handles decode back-pressure and
//            branch/jump redirect, including abandoning an in-flight read.
// Ports    : CLK, RST (async, active-low)
//            IMemAddr/IMemReadEnable        -> fetch request
//            IMemReadData/IMemAck           <- fetch response
//            Redirect/RedirectPC            <- new fetch path (one-cycle pulse)
//            ID_Stall                       <- decode back-pressure
//            ID_Valid/ID_Instruction/ID_PC  -> FIFO head to decode
//            BufferCount                    -> occupied FIFO entries
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] PC_INIT = '0,
    parameter logic [WIDTH-1:0] PC_INCR = WIDTH'(4)
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic [WIDTH-1:0]           IMemAddr,
    output logic                       IMemReadEnable,
    input  logic [WIDTH-1:0]           IMemReadData,
    input  logic                       IMemAck,
    input  logic                       Redirect,
    input  logic [WIDTH-1:0]           RedirectPC,
    input  logic                       ID_Stall,
    output logic                       ID_Valid,
    output logic [WIDTH-1:0]           ID_Instruction,
    output logic [WIDTH-1:0]           ID_PC,
    output logic [$clog2(DEPTH+1)-1:0] BufferCount
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    // While in DISCARD the fetch PC still holds the abandoned address, which
    // keeps IMemAddr stable for the memory; the new path waits in r_pending_pc.
    logic [WIDTH-1:0]   r_fetch_pc;
    logic [WIDTH-1:0]   r_pending_pc;

    logic [WIDTH-1:0]   r_fifo_pc    [DEPTH];
    logic [WIDTH-1:0]   r_fifo_instr [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;

    logic               w_push;
    logic               w_pop;

    // Redirect overrides both push and pop: the FIFO is flushed instead.
    assign w_push = (r_state == c_REQ) && IMemAck && !Redirect;
    assign w_pop  = (r_count != '0) && !ID_Stall && !Redirect;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (Redirect) begin
            // An unacknowledged read must still be retired before the new
            // path can be requested.
            if ((r_state == c_IDLE) || IMemAck) begin
                w_state_next = c_REQ;
            end else begin
                w_state_next = c_DISCARD;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_count < c_DEPTH_CNT) begin
                        w_state_next = c_REQ;
                    end
                end
                c_REQ: begin
                    if (IMemAck) begin
                        // Never issue a fetch the FIFO could not absorb.
                        w_state_next = (w_count_next < c_DEPTH_CNT) ? c_REQ : c_IDLE;
                    end
                end
                c_DISCARD: begin
                    if (IMemAck) begin
                        w_state_next = c_REQ;
                    end
                end
                default: w_state_next = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        IMemReadEnable = (r_state == c_REQ) || (r_state == c_DISCARD);
        IMemAddr       = r_fetch_pc;
    end

    // ------------------------------------------------------------------------
    // Fetch PC and pending redirect target
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_fetch_pc   <= PC_INIT;
            r_pending_pc <= PC_INIT;
        end else if (Redirect) begin
            if (w_state_next == c_DISCARD) begin
                r_pending_pc <= RedirectPC;
            end else begin
                r_fetch_pc <= RedirectPC;
            end
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + PC_INCR;
        end else if ((r_state == c_DISCARD) && IMemAck) begin
            r_fetch_pc <= r_pending_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Prefetch FIFO (DEPTH is a power of two, so pointers wrap naturally)
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (Redirect) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
                r_fifo_instr[r_wr_ptr] <= IMemReadData;
                r_wr_ptr               <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
        end
    end

    assign ID_Valid       = (r_count != '0);
    assign ID_Instruction = r_fifo_instr[r_rd_ptr];
    assign ID_PC          = r_fifo_pc[r_rd_ptr];
    assign BufferCount    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Self-checking bench for instruction_fetch_unit. A memory
//            responder acknowledges requests after a programmable latency;
//            a scoreboard queues every accepted instruction and compares it
//            when decode consumes the FIFO head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] PC0   = 32'h0000_0100;

    logic             clk            = 1'b0;
    logic             rst_n          = 1'b0;
    logic [WIDTH-1:0] IMemAddr;
    logic             IMemReadEnable;
    logic [WIDTH-1:0] IMemReadData   = '0;
    logic             IMemAck        = 1'b0;
    logic             Redirect       = 1'b0;
    logic [WIDTH-1:0] RedirectPC     = '0;
    logic             ID_Stall       = 1'b0;
    logic             ID_Valid;
    logic [WIDTH-1:0] ID_Instruction;
    logic [WIDTH-1:0] ID_PC;
    logic [CW-1:0]    BufferCount;

    int checks   = 0;
    int failures = 0;

    int mem_lat  = 0;
    int wait_cnt = 0;
    int n_push   = 0;

    logic [63:0] sb_q[$];
    logic        sb_disc = 1'b0;
    logic [63:0] mon_exp;

    instruction_fetch_unit #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PC_INIT (PC0),
        .PC_INCR (32'd4)
    ) dut (
        .CLK            (clk),
        .RST            (rst_n),
        .IMemAddr       (IMemAddr),
        .IMemReadEnable (IMemReadEnable),
        .IMemReadData   (IMemReadData),
        .IMemAck        (IMemAck),
        .Redirect       (Redirect),
        .RedirectPC     (RedirectPC),
        .ID_Stall       (ID_Stall),
        .ID_Valid       (ID_Valid),
        .ID_Instruction (ID_Instruction),
        .ID_PC          (ID_PC),
        .BufferCount    (BufferCount)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Memory responder: decides the ack for the current cycle at negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (IMemAck) wait_cnt = 0;
            if (rst_n && IMemReadEnable) begin
                if (wait_cnt >= mem_lat) begin
                    IMemAck      = 1'b1;
                    IMemReadData = instr_of(IMemAddr);
                end else begin
                    IMemAck      = 1'b0;
                    IMemReadData = 32'hBAD0_BAD0;
                    wait_cnt     = wait_cnt + 1;
                end
            end else begin
                IMemAck      = 1'b0;
                IMemReadData = 32'hBAD0_BAD0;
                wait_cnt     = 0;
            end
        end
    end

    // Scoreboard: compare heads consumed by decode, then apply this cycle's
    // flush or push to the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                sb_q.delete();
                sb_disc = 1'b0;
            end else begin
                checks++;
                if (BufferCount !== CW'(sb_q.size())) begin
                    failures++;
                    $display("FAIL sb_count: actual=%0d expected=%0d", BufferCount, sb_q.size());
                end
                checks++;
                if (BufferCount > CW'(DEPTH)) begin
                    failures++;
                    $display("FAIL count_bound: actual=%0d expected<=%0d", BufferCount, DEPTH);
                end
                checks++;
                if (ID_Valid !== (sb_q.size() != 0)) begin
                    failures++;
                    $display("FAIL sb_valid: actual=%b expected=%b", ID_Valid, sb_q.size() != 0);
                end
                if (!Redirect && ID_Valid && !ID_Stall) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_underflow: actual=pop expected=empty");
                    end else begin
                        mon_exp = sb_q.pop_front();
                        if ({ID_PC, ID_Instruction} !== mon_exp) begin
                            failures++;
                            $display("FAIL sb_head: actual=%h_%h expected=%h_%h",
                                     ID_PC, ID_Instruction, mon_exp[63:32], mon_exp[31:0]);
                        end
                    end
                end
                if (Redirect) begin
                    sb_q.delete();
                    sb_disc = IMemReadEnable && !IMemAck;
                end else if (IMemReadEnable && IMemAck) begin
                    if (sb_disc) begin
                        sb_disc = 1'b0;
                    end else begin
                        sb_q.push_back({IMemAddr, IMemReadData});
                        n_push++;
                    end
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        Redirect = 1'b0;
        repeat (2) next_cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ID_Stall = 1'b0;
        mem_lat  = 0;
        rst_n    = 1'b0;
        repeat (2) next_cyc();
        checks++; if (IMemReadEnable !== 1'b0) begin failures++; $display("FAIL rst_re: actual=%b expected=0", IMemReadEnable); end
        checks++; if (ID_Valid !== 1'b0) begin failures++; $display("FAIL rst_valid: actual=%b expected=0", ID_Valid); end
        checks++; if (BufferCount !== '0) begin failures++; $display("FAIL rst_count: actual=%0d expected=0", BufferCount); end
        checks++; if (IMemAddr !== PC0) begin failures++; $display("FAIL rst_addr: actual=%h expected=%h", IMemAddr, PC0); end
        checks++; if (ID_PC !== '0) begin failures++; $display("FAIL rst_idpc: actual=%h expected=0", ID_PC); end
        checks++; if (ID_Instruction !== '0) begin failures++; $display("FAIL rst_instr: actual=%h expected=0", ID_Instruction); end
        rst_n = 1'b1;
        #1;
        checks++; if (IMemReadEnable !== 1'b0) begin failures++; $display("FAIL first_req_early: actual=%b expected=0", IMemReadEnable); end
        next_cyc();
        checks++; if (IMemReadEnable !== 1'b1 || IMemAddr !== PC0) begin
            failures++; $display("FAIL first_req: actual=%b/%h expected=1/%h", IMemReadEnable, IMemAddr, PC0);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            next_cyc();
            checks++; if (IMemReadEnable !== 1'b1 || IMemAddr !== PC0 + 32'(4 * i)) begin
                failures++; $display("FAIL seq_addr: actual=%h expected=%h", IMemAddr, PC0 + 32'(4 * i));
            end
            checks++; if (ID_Valid !== 1'b1 || ID_PC !== PC0 + 32'(4 * (i - 1))) begin
                failures++; $display("FAIL seq_idpc: actual=%b/%h expected=1/%h", ID_Valid, ID_PC, PC0 + 32'(4 * (i - 1)));
            end
        end
    endtask

    task automatic test_full_fifo();
        int          p0;
        logic        seen;
        logic [31:0] resume;
        ID_Stall = 1'b1;
        mem_lat  = 0;
        apply_reset();
        p0 = n_push;
        repeat (10) next_cyc();
        checks++; if (IMemReadEnable !== 1'b0) begin failures++; $display("FAIL full_re: actual=%b expected=0", IMemReadEnable); end
        checks++; if (BufferCount !== CW'(DEPTH)) begin failures++; $display("FAIL full_count: actual=%0d expected=%0d", BufferCount, DEPTH); end
        checks++; if (n_push - p0 != DEPTH) begin failures++; $display("FAIL full_acks: actual=%0d expected=%0d", n_push - p0, DEPTH); end
        ID_Stall = 1'b0;
        seen     = 1'b0;
        resume   = '0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ID_Valid !== 1'b1 || ID_PC !== PC0 + 32'(4 * i)) begin
                failures++; $display("FAIL drain_order: actual=%b/%h expected=1/%h", ID_Valid, ID_PC, PC0 + 32'(4 * i));
            end
            if (IMemReadEnable && !seen) begin seen = 1'b1; resume = IMemAddr; end
            next_cyc();
        end
        for (int i = 0; i < 6 && !seen; i++) begin
            if (IMemReadEnable) begin seen = 1'b1; resume = IMemAddr; end
            next_cyc();
        end
        checks++; if (!seen || resume !== PC0 + 32'h10) begin
            failures++; $display("FAIL resume_addr: actual=%b/%h expected=1/%h", seen, resume, PC0 + 32'h10);
        end
    endtask

    task automatic test_slow_memory();
        int          held;
        int          nack;
        logic [31:0] cur;
        ID_Stall = 1'b1;
        mem_lat  = 3;
        apply_reset();
        held = 0;
        nack = 0;
        cur  = '0;
        for (int c = 0; c < 40 && nack < 3; c++) begin
            @(negedge clk);
            #2;
            if (IMemReadEnable) begin
                if (held == 0) begin
                    cur = IMemAddr;
                end else begin
                    checks++; if (IMemAddr !== cur) begin failures++; $display("FAIL slow_hold: actual=%h expected=%h", IMemAddr, cur); end
                end
                held++;
                if (IMemAck) begin
                    checks++; if (held != 4) begin failures++; $display("FAIL slow_latency: actual=%0d expected=4", held); end
                    checks++; if (cur !== PC0 + 32'(4 * nack)) begin failures++; $display("FAIL slow_addr: actual=%h expected=%h", cur, PC0 + 32'(4 * nack)); end
                    nack++;
                    held = 0;
                    next_cyc();
                    checks++; if (BufferCount !== CW'(nack)) begin failures++; $display("FAIL slow_push: actual=%0d expected=%0d", BufferCount, nack); end
                end
            end
        end
        checks++; if (nack != 3) begin failures++; $display("FAIL slow_timeout: actual=%0d expected=3", nack); end
        mem_lat = 0;
    endtask

    task automatic test_redirect_in_flight();
        logic found;
        int   held;
        ID_Stall = 1'b1;
        mem_lat  = 3;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            next_cyc();
            if (IMemReadEnable && IMemAddr == PC0 + 32'h8) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rif_wait: actual=0 expected=1"); end
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0400;
        next_cyc();
        Redirect = 1'b0;
        ID_Stall = 1'b0;
        checks++; if (ID_Valid !== 1'b0 || BufferCount !== '0) begin
            failures++; $display("FAIL rif_flush: actual=%b/%0d expected=0/0", ID_Valid, BufferCount);
        end
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(IMemReadEnable && IMemAddr == PC0 + 32'h8)) break;
            held++;
            next_cyc();
        end
        checks++; if (held != 3) begin failures++; $display("FAIL rif_hold: actual=%0d expected=3", held); end
        checks++; if (IMemReadEnable !== 1'b1 || IMemAddr !== 32'h0000_0400) begin
            failures++; $display("FAIL rif_newreq: actual=%b/%h expected=1/00000400", IMemReadEnable, IMemAddr);
        end
        for (int i = 0; i < 10 && !ID_Valid; i++) next_cyc();
        checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h0000_0400 || ID_Instruction !== instr_of(32'h400)) begin
            failures++; $display("FAIL rif_first_pc: actual=%b/%h/%h expected=1/00000400/%h", ID_Valid, ID_PC, ID_Instruction, instr_of(32'h400));
        end
        mem_lat = 0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] old;
        ID_Stall = 1'b0;
        mem_lat  = 0;
        apply_reset();
        repeat (3) next_cyc();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0600;
        next_cyc();
        Redirect = 1'b0;
        checks++; if (IMemReadEnable !== 1'b1 || IMemAddr !== 32'h0000_0600 || ID_Valid !== 1'b0) begin
            failures++; $display("FAIL sim_ack_redirect: actual=%b/%h/%b expected=1/00000600/0", IMemReadEnable, IMemAddr, ID_Valid);
        end
        next_cyc();
        checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h0000_0600) begin
            failures++; $display("FAIL sim_first_pc: actual=%b/%h expected=1/00000600", ID_Valid, ID_PC);
        end
        old        = IMemAddr;
        mem_lat    = 3;
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0700;
        next_cyc();
        RedirectPC = 32'h0000_0800;
        checks++; if (IMemAddr !== old) begin failures++; $display("FAIL disc_hold1: actual=%h expected=%h", IMemAddr, old); end
        next_cyc();
        Redirect = 1'b0;
        checks++; if (IMemAddr !== old || ID_Valid !== 1'b0) begin
            failures++; $display("FAIL disc_hold2: actual=%h/%b expected=%h/0", IMemAddr, ID_Valid, old);
        end
        for (int i = 0; i < 10 && IMemAddr == old; i++) next_cyc();
        mem_lat = 0;
        checks++; if (IMemReadEnable !== 1'b1 || IMemAddr !== 32'h0000_0800) begin
            failures++; $display("FAIL disc_second: actual=%b/%h expected=1/00000800", IMemReadEnable, IMemAddr);
        end
        for (int i = 0; i < 10 && !ID_Valid; i++) next_cyc();
        checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h0000_0800) begin
            failures++; $display("FAIL disc_first_pc: actual=%b/%h expected=1/00000800", ID_Valid, ID_PC);
        end
    endtask

    task automatic test_wraparound();
        int p0;
        ID_Stall = 1'b0;
        mem_lat  = 0;
        apply_reset();
        next_cyc();
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFF8;
        next_cyc();
        Redirect = 1'b0;
        checks++; if (IMemAddr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_a0: actual=%h expected=fffffff8", IMemAddr); end
        next_cyc();
        checks++; if (IMemAddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_a1: actual=%h expected=fffffffc", IMemAddr); end
        next_cyc();
        checks++; if (IMemAddr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_a2: actual=%h expected=00000000", IMemAddr); end
        next_cyc();
        checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h0 || ID_Instruction !== instr_of(32'h0)) begin
            failures++; $display("FAIL wrap_head: actual=%b/%h/%h expected=1/00000000/%h", ID_Valid, ID_PC, ID_Instruction, instr_of(32'h0));
        end
        p0 = n_push;
        for (int i = 0; i < 60; i++) begin
            ID_Stall = ($urandom_range(0, 2) == 0);
            mem_lat  = $urandom_range(0, 2);
            next_cyc();
        end
        ID_Stall = 1'b0;
        mem_lat  = 0;
        repeat (10) next_cyc();
        checks++; if (n_push - p0 < 3 * DEPTH + 1) begin
            failures++; $display("FAIL wrap_pushes: actual=%0d expected>=%0d", n_push - p0, 3 * DEPTH + 1);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full_fifo();
        test_slow_memory();
        test_redirect_in_flight();
        test_simultaneous();
        test_wraparound();
        repeat (2) next_cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
